// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit hex word onto an 8-digit multiplexed 7-segment display.
// The word is latched once per frame so mid-frame updates never tear the image.
module seg7_scan_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter bit BLANK_F     = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]      AN_OFF   = AN_ACT_LOW  ? 8'hFF : 8'h00;
  localparam logic [6:0]      SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = SEG_ACT_LOW ? 1'b1  : 1'b0;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          load_pend_q, load_pend_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nibble;
  logic [7:0]    an_act;
  logic [6:0]    seg_act;

  // Active-high {g,f,e,d,c,b,a}; the shifter pads with F, which can be shown dark.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    if (BLANK_F && (n == 4'hF)) s = 7'h00;
    return s;
  endfunction

  always_comb begin
    prescaler_d  = prescaler_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    load_pend_d  = load_pend_q;

    tick = en && (prescaler_q == PRE_LAST);
    wrap = tick && (idx_q == 3'd7);

    if (en) begin
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      if (tick) idx_d = idx_q + 3'd1;
      if (wrap || load_pend_q) snap_d = data;
      load_pend_d = 1'b0;
    end

    // Anode stays dark on the first cycle of a slot while the segments settle.
    nibble       = snap_q[{idx_q, 2'b00} +: 4];
    an_act       = (en && (prescaler_q != '0)) ? (8'h01 << idx_q) : 8'h00;
    seg_act      = en ? hex_to_seg(nibble) : 7'h00;
    an_d         = an_act ^ AN_OFF;
    seg_d        = seg_act ^ SEG_OFF;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q  <= '0;
      idx_q        <= 3'd0;
      snap_q       <= 32'hFFFF_FFFF;
      load_pend_q  <= 1'b1;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      load_pend_q  <= load_pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = DP_OFF;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4; a second instance
// with BLANK_F=0 shares the stimulus so the literal "F" glyph can be checked.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] data;
  logic [7:0]  an,  an_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp,  dp_nb;
  logic        frame_done, frame_done_nb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]     data;
    logic [0:7][6:0] exp_seg;
    logic [0:7][6:0] exp_nb;
  } vec_t;

  vec_t vecs[3];

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_F(1'b1), .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_F(1'b0), .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_done(frame_done_nb)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] d, input logic e);
    data = d;
    en   = e;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to the negedge where frame_done is high, with a cycle budget.
  task automatic wait_frame();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    checkOutput("frame_timeout", 32'(frame_done), 32'd1);
  endtask

  // Entered at the frame_done negedge; walks all 8 slots (dark + 3 lit cycles each)
  // and ends on the negedge where the next frame_done must appear.
  task automatic check_frame(input logic [0:7][6:0] exp_seg, input logic [0:7][6:0] exp_nb,
                             input int tear_digit, input logic [31:0] tear_data);
    logic [7:0] an_exp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == tear_digit) applyStimulus(tear_data, 1'b1);
      checkOutput($sformatf("dark_an_d%0d", k), 32'(an), 32'hFF);
      checkOutput($sformatf("dark_fd_d%0d", k), 32'(frame_done), 32'd0);
      an_exp = ~(8'h01 << k);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        checkOutput($sformatf("an_d%0d", k), 32'(an), 32'(an_exp));
        checkOutput($sformatf("seg_d%0d", k), 32'(seg), 32'(exp_seg[k]));
        checkOutput($sformatf("seg_nb_d%0d", k), 32'(seg_nb), 32'(exp_nb[k]));
      end
    end
    checkOutput("frame_period", 32'(frame_done), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h2011_9127,
                {7'h78, 7'h24, 7'h79, 7'h10, 7'h79, 7'h79, 7'h40, 7'h24},
                {7'h78, 7'h24, 7'h79, 7'h10, 7'h79, 7'h79, 7'h40, 7'h24}};
    vecs[1] = '{32'hFFFF_1234,
                {7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
                {7'h19, 7'h30, 7'h24, 7'h79, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    vecs[2] = '{32'h0000_0000,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

    rst = 1'b1;
    applyStimulus(32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_an", 32'(an), 32'hFF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_dp", 32'(dp), 32'd1);
    checkOutput("reset_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Table-driven frames; each new word is picked up at the next frame boundary.
    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v].data, 1'b1);
      wait_frame();
      check_frame(vecs[v].exp_seg, vecs[v].exp_nb, -1, 32'h0);
    end

    // Tear guard: data cleared while digit 3 scans; old frame completes, zeros follow.
    applyStimulus(32'hFFFF_1234, 1'b1);
    wait_frame();
    check_frame(vecs[1].exp_seg, vecs[1].exp_nb, 3, 32'h0);
    check_frame(vecs[2].exp_seg, vecs[2].exp_nb, -1, 32'h0);

    // Enable pause in the middle of digit 2's slot, then resume on the same digit.
    applyStimulus(32'h2011_9127, 1'b1);
    wait_frame();
    wait_frame();
    repeat (10) @(negedge clk);
    checkOutput("pre_pause_an", 32'(an), 32'hFB);
    applyStimulus(32'h2011_9127, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("pause_an", 32'(an), 32'hFF);
      checkOutput("pause_seg", 32'(seg), 32'h7F);
      checkOutput("pause_fd", 32'(frame_done), 32'd0);
    end
    applyStimulus(32'h2011_9127, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("resume_an", 32'(an), 32'hFB);
      checkOutput("resume_seg", 32'(seg), 32'h79);
    end
    @(negedge clk);
    checkOutput("resume_dark_an", 32'(an), 32'hFF);
    checkOutput("resume_dark_seg", 32'(seg), 32'h10);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      checkOutput("resume_fd", 32'(frame_done), (i == 18) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset asserted between clock edges while the display is lit.
    wait_frame();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_an", 32'(an), 32'hFF);
    checkOutput("async_rst_seg", 32'(seg), 32'h7F);
    checkOutput("async_rst_fd", 32'(frame_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
